// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity codes and frame-format helpers for the UART TX engine
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5,
      ST_BREAK  = 3'd6
   } tx_state_t;

   localparam logic [2:0] PAR_NONE  = 3'd0;
   localparam logic [2:0] PAR_EVEN  = 3'd1;
   localparam logic [2:0] PAR_ODD   = 3'd2;
   localparam logic [2:0] PAR_MARK  = 3'd3;
   localparam logic [2:0] PAR_SPACE = 3'd4;

   // Data-width code to bit count: 0..4 -> 5..9, anything else falls back to 8.
   function automatic logic [3:0] data_bits(input logic [2:0] code);
      if (code <= 3'd4) begin
         return {1'b0, code} + 4'd5;
      end
      return 4'd8;
   endfunction

   // Out-of-range parity codes collapse to no parity so the FSM only sees legal codes.
   function automatic logic [2:0] parity_code(input logic [2:0] code);
      if (code <= PAR_SPACE) begin
         return code;
      end
      return PAR_NONE;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - counts oversampled baud ticks and flags the end of each bit time
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   input  logic baud_tick_i,
   output logic bit_end_o
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   assign bit_end_o = en_i & baud_tick_i & (cnt_q == LAST_TICK);

   // Clear wins so a tick on the state-entry edge never counts toward the new bit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 4'd0;
      end else if (en_i & baud_tick_i) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Tick counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// rtl/uart_tx_frame_engine.sv - per-frame configurable UART transmitter with break generation
module uart_tx_frame_engine
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16,
   parameter int MAX_DATA_W = 9,
   parameter int BREAK_EN   = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  baud_tick,
   input  logic                  tx_valid,
   input  logic [MAX_DATA_W-1:0] tx_data,
   output logic                  tx_ready,
   input  logic [2:0]            cfg_data,
   input  logic [2:0]            cfg_parity,
   input  logic                  cfg_stop2,
   input  logic                  break_req,
   output logic                  txd,
   output logic                  tx_busy,
   output logic                  tx_done
);

   tx_state_t             state_q;
   logic                  txd_q;
   logic                  busy_q;
   logic                  done_q;
   logic [3:0]            idx_q;
   logic [MAX_DATA_W-1:0] data_q;
   logic [3:0]            nbits_q;
   logic [2:0]            par_q;
   logic                  stop2_q;
   logic                  from_brk_q;

   logic                  brk_eff;
   logic                  bit_state;
   logic                  timer_clr;
   logic                  bit_end;
   logic [3:0]            idx_nx;
   logic                  last_bit;
   logic                  par_en;
   logic [MAX_DATA_W-1:0] data_mask;
   logic                  par_bit;

   assign brk_eff   = break_req & (BREAK_EN != 0);
   assign tx_ready  = (state_q == ST_IDLE) & ~brk_eff;
   assign bit_state = (state_q != ST_IDLE) & (state_q != ST_BREAK);
   // IDLE and BREAK hold the counter at zero; bit_end wraps it, so every entry starts fresh.
   assign timer_clr = ~bit_state | bit_end;
   assign idx_nx    = idx_q + 4'd1;
   assign last_bit  = (idx_q == nbits_q - 4'd1);
   assign par_en    = (par_q != PAR_NONE);
   assign data_mask = MAX_DATA_W'((10'd1 << nbits_q) - 10'd1);

   assign txd     = txd_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

   // Parity over the active data bits only; unused upper bits are masked off.
   always_comb begin
      par_bit = 1'b0;
      case (par_q)
         PAR_EVEN: par_bit = ^(data_q & data_mask);
         PAR_ODD:  par_bit = ~^(data_q & data_mask);
         PAR_MARK: par_bit = 1'b1;
         default:  par_bit = 1'b0;
      endcase
   end

   uart_bit_timer #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_bit_timer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr_i       (timer_clr),
      .en_i        (bit_state),
      .baud_tick_i (baud_tick),
      .bit_end_o   (bit_end)
   );

   // Frame sequencer with registered line, busy and done outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         idx_q      <= 4'd0;
         data_q     <= '0;
         nbits_q    <= 4'd0;
         par_q      <= PAR_NONE;
         stop2_q    <= 1'b0;
         from_brk_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               txd_q      <= 1'b1;
               busy_q     <= 1'b0;
               from_brk_q <= 1'b0;
               if (brk_eff) begin
                  state_q <= ST_BREAK;
                  txd_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (tx_valid) begin
                  data_q  <= tx_data;
                  nbits_q <= data_bits(cfg_data);
                  par_q   <= parity_code(cfg_parity);
                  stop2_q <= cfg_stop2;
                  state_q <= ST_START;
                  txd_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state_q <= ST_DATA;
                  idx_q   <= 4'd0;
                  txd_q   <= data_q[0];
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (last_bit) begin
                     idx_q <= 4'd0;
                     if (par_en) begin
                        state_q <= ST_PARITY;
                        txd_q   <= par_bit;
                     end else begin
                        state_q <= ST_STOP1;
                        txd_q   <= 1'b1;
                     end
                  end else begin
                     idx_q <= idx_nx;
                     txd_q <= data_q[idx_nx];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state_q <= ST_STOP1;
                  txd_q   <= 1'b1;
               end
            end
            ST_STOP1: begin
               txd_q <= 1'b1;
               if (bit_end) begin
                  // The mark bit after a break is always a single bit and never reports done.
                  if (stop2_q & ~from_brk_q) begin
                     state_q <= ST_STOP2;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= ~from_brk_q;
                  end
               end
            end
            ST_STOP2: begin
               txd_q <= 1'b1;
               if (bit_end) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_BREAK: begin
               txd_q <= 1'b0;
               if (!brk_eff) begin
                  state_q    <= ST_STOP1;
                  txd_q      <= 1'b1;
                  from_brk_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               txd_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb/tb_uart_tx_frame_engine.sv - randomized self-checking bench for uart_tx_frame_engine
`timescale 1ns/1ps
module tb_uart_tx_frame_engine;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       baud_tick;
   logic       tx_valid;
   logic [8:0] tx_data;
   logic       tx_ready;
   logic [2:0] cfg_data;
   logic [2:0] cfg_parity;
   logic       cfg_stop2;
   logic       break_req;
   logic       txd;
   logic       tx_busy;
   logic       tx_done;

   int n_chk  = 0;
   int n_fail = 0;

   uart_tx_frame_engine #(
      .OVERSAMPLE (OS),
      .MAX_DATA_W (9),
      .BREAK_EN   (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .baud_tick  (baud_tick),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .cfg_data   (cfg_data),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .break_req  (break_req),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // Sends one frame and checks the line tick by tick against the ideal waveform.
   // Returns in the tx_done cycle (or after a planted reset when rst_idx >= 0).
   task automatic run_frame(input logic [8:0] data, input logic [2:0] cd, input logic [2:0] cp,
                            input logic s2, input bit hold, input int brk_at, input int rst_idx);
      bit       exp_q[$];
      int       nb;
      int       ones;
      int       cnt;
      int       idx;
      int       cyc;
      bit       tk;
      logic [3:0] exp_v;
      exp_q = {};
      nb    = (cd <= 3'd4) ? int'(cd) + 5 : 8;
      ones  = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(data[i]);
         ones += int'(data[i]);
      end
      case (cp)
         3'd1: exp_q.push_back(bit'(ones % 2));
         3'd2: exp_q.push_back(bit'(1 - (ones % 2)));
         3'd3: exp_q.push_back(1'b1);
         3'd4: exp_q.push_back(1'b0);
         default: ;
      endcase
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);

      tx_data = data; cfg_data = cd; cfg_parity = cp; cfg_stop2 = s2; tx_valid = 1'b1;
      n_chk++;
      if (tx_ready !== 1'b1) begin
         n_fail++; $display("FAIL accept_ready: got %b want 1", tx_ready);
      end
      baud_tick = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_chk++;
      if ({txd, tx_busy, tx_done} !== 3'b010) begin
         n_fail++; $display("FAIL start_entry: txd/busy/done got %b want 010", {txd, tx_busy, tx_done});
      end
      if (!hold) tx_valid = 1'b0;
      cnt = 0;
      cyc = 0;
      forever begin
         tx_data    = 9'($urandom);
         cfg_data   = 3'($urandom);
         cfg_parity = 3'($urandom);
         cfg_stop2  = 1'($urandom);
         if (cyc == brk_at) break_req = 1'b1;
         tk = 1'($urandom_range(0, 1));
         baud_tick = tk;
         @(posedge clk); #1;
         cyc++;
         if (tk) cnt++;
         idx = cnt / OS;
         if (idx >= exp_q.size()) begin
            exp_v = {1'b1, 1'b0, 1'b1, ~break_req};
            n_chk++;
            if ({txd, tx_busy, tx_done, tx_ready} !== exp_v) begin
               n_fail++;
               $display("FAIL frame_end: txd/busy/done/ready got %b want %b (ticks %0d)",
                        {txd, tx_busy, tx_done, tx_ready}, exp_v, cnt);
            end
            break;
         end
         exp_v = {logic'(exp_q[idx]), 1'b1, 1'b0, 1'b0};
         n_chk++;
         if ({txd, tx_busy, tx_done, tx_ready} !== exp_v) begin
            n_fail++;
            $display("FAIL frame_bit%0d: txd/busy/done/ready got %b want %b (tick %0d)",
                     idx, {txd, tx_busy, tx_done, tx_ready}, exp_v, cnt);
         end
         if (rst_idx >= 0 && idx == rst_idx) begin
            tx_valid = 1'b0;
            #2 reset_n = 1'b0;
            #1;
            n_chk++;
            if ({txd, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
               n_fail++; $display("FAIL async_reset: txd/busy/done/ready got %b want 1001",
                                  {txd, tx_busy, tx_done, tx_ready});
            end
            @(posedge clk); #1;
            reset_n = 1'b1;
            return;
         end
         if (cyc > 3000) begin
            n_fail++; $display("FAIL frame_timeout: got %0d ticks want %0d", cnt, exp_q.size() * OS);
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; baud_tick = 1'b0; tx_valid = 1'b0; tx_data = '0;
      cfg_data = 3'd3; cfg_parity = 3'd0; cfg_stop2 = 1'b0; break_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({txd, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
         n_fail++; $display("FAIL reset_state: got %b want 1001", {txd, tx_busy, tx_done, tx_ready});
      end
      reset_n = 1'b1;
      repeat (2) begin
         baud_tick = 1'b1;
         @(posedge clk); #1;
      end
      n_chk++;
      if ({txd, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
         n_fail++; $display("FAIL idle_after_reset: got %b want 1001", {txd, tx_busy, tx_done, tx_ready});
      end
   endtask

   task automatic test_8n1;
      run_frame(9'h055, 3'd3, 3'd0, 1'b0, 1'b0, -1, -1);
   endtask

   task automatic test_7e2;
      run_frame(9'h1A3, 3'd2, 3'd1, 1'b1, 1'b0, -1, -1);
   endtask

   task automatic test_9o1_and_mark;
      run_frame(9'h1FF, 3'd4, 3'd2, 1'b0, 1'b0, -1, -1);
      run_frame(9'($urandom), 3'd0, 3'd3, 1'b0, 1'b0, -1, -1);
      run_frame(9'($urandom), 3'd1, 3'd4, 1'b1, 1'b0, -1, -1);
   endtask

   task automatic test_random_frames;
      for (int k = 0; k < 6; k++) begin
         run_frame(9'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b0, -1, -1);
      end
   endtask

   task automatic test_back_to_back;
      run_frame(9'($urandom), 3'd3, 3'd0, 1'b0, 1'b1, -1, -1);
      run_frame(9'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'b1, -1, -1);
      run_frame(9'($urandom), 3'd4, 3'd1, 1'b1, 1'b0, -1, -1);
   endtask

   task automatic test_break;
      int cnt;
      int cyc;
      bit tk;
      run_frame(9'($urandom), 3'd3, 3'd0, 1'b0, 1'b0, 37, -1);
      tx_valid = 1'b1;
      n_chk++;
      if (tx_ready !== 1'b0) begin
         n_fail++; $display("FAIL break_wins_ready: got %b want 0", tx_ready);
      end
      for (int k = 0; k < 12; k++) begin
         baud_tick = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n_chk++;
         if ({txd, tx_busy, tx_done, tx_ready} !== 4'b0100) begin
            n_fail++; $display("FAIL break_hold%0d: got %b want 0100", k, {txd, tx_busy, tx_done, tx_ready});
         end
      end
      tx_valid = 1'b0; break_req = 1'b0;
      baud_tick = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n_chk++;
      if ({txd, tx_busy, tx_done} !== 3'b110) begin
         n_fail++; $display("FAIL break_exit: got %b want 110", {txd, tx_busy, tx_done});
      end
      cnt = 0;
      cyc = 0;
      while (cnt < OS && cyc < 500) begin
         tk = 1'($urandom_range(0, 1));
         baud_tick = tk;
         @(posedge clk); #1;
         cyc++;
         if (tk) cnt++;
         n_chk++;
         if (cnt < OS) begin
            if ({txd, tx_busy, tx_done, tx_ready} !== 4'b1100) begin
               n_fail++; $display("FAIL break_mark: got %b want 1100 (tick %0d)", {txd, tx_busy, tx_done, tx_ready}, cnt);
            end
         end else if ({txd, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
            n_fail++; $display("FAIL break_end_no_done: got %b want 1001", {txd, tx_busy, tx_done, tx_ready});
         end
      end
      if (cnt < OS) begin
         n_fail++; $display("FAIL break_timeout: got %0d ticks want %0d", cnt, OS);
      end
   endtask

   task automatic test_reset_mid_frame;
      run_frame(9'($urandom), 3'd3, 3'd0, 1'b0, 1'b0, -1, 4);
      run_frame(9'($urandom), 3'd3, 3'd0, 1'b0, 1'b0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_7e2();
      test_9o1_and_mark();
      test_random_frames();
      test_back_to_back();
      test_break();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
